// File: rtl/id_checker.sv
// id_checker: acknowledges decoded IDs, searches an authorization table and enforces a lockout after repeated denials
module id_checker #(
  parameter int NUM_ENTRIES    = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ID_vld,
  input  logic [7:0]    ID,
  output logic          clr_ID_vld,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  output logic          result_vld,
  output logic          granted,
  output logic          denied,
  input  logic          result_ack,
  output logic          locked,
  output logic [3:0]    fail_cnt
);
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, RESPOND, LOCKOUT} state_t;

  state_t               state, state_n;
  logic [7:0]           tbl_data [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tbl_vld;
  logic [7:0]           id_q, id_q_n;
  logic [IW-1:0]        idx, idx_n;
  logic [TW-1:0]        timer, timer_n;
  logic                 clr_n, rvld_n, gr_n, dn_n, lk_n;
  logic [3:0]           fc_n, fc_inc;
  logic                 hit, last;

  assign hit    = tbl_vld[idx] && (tbl_data[idx] == id_q);
  assign last   = idx == IW'(NUM_ENTRIES - 1);
  assign fc_inc = (fail_cnt == 4'(MAX_FAILS)) ? fail_cnt : fail_cnt + 4'd1;

  // Writes use registered contents for the compare, so a same-cycle write to the searched entry sees old data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl_data[i] <= '0;
      tbl_vld <= '0;
    end else if (wr_en) begin
      tbl_data[wr_idx] <= wr_data;
      tbl_vld[wr_idx]  <= wr_valid;
    end
  end

  always_comb begin
    state_n = state;
    id_q_n  = id_q;
    idx_n   = idx;
    timer_n = timer;
    clr_n   = 1'b0;
    rvld_n  = result_vld;
    gr_n    = granted;
    dn_n    = denied;
    lk_n    = locked;
    fc_n    = fail_cnt;
    case (state)
      IDLE: begin
        if (ID_vld && !clr_ID_vld) begin
          id_q_n  = ID;
          clr_n   = 1'b1;
          idx_n   = '0;
          state_n = SEARCH;
        end
      end
      SEARCH: begin
        if (hit || last) begin
          rvld_n  = 1'b1;
          gr_n    = hit;
          dn_n    = !hit;
          state_n = RESPOND;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      RESPOND: begin
        if (result_ack) begin
          rvld_n  = 1'b0;
          gr_n    = 1'b0;
          dn_n    = 1'b0;
          state_n = IDLE;
          fc_n    = granted ? 4'd0 : fc_inc;
          if (!granted && fc_inc == 4'(MAX_FAILS)) begin
            lk_n    = 1'b1;
            timer_n = TW'(LOCKOUT_CYCLES - 1);
            state_n = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        clr_n = ID_vld && !clr_ID_vld;
        if (timer == '0) begin
          lk_n    = 1'b0;
          fc_n    = 4'd0;
          state_n = IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      id_q       <= '0;
      idx        <= '0;
      timer      <= '0;
      clr_ID_vld <= 1'b0;
      result_vld <= 1'b0;
      granted    <= 1'b0;
      denied     <= 1'b0;
      locked     <= 1'b0;
      fail_cnt   <= 4'd0;
    end else begin
      state      <= state_n;
      id_q       <= id_q_n;
      idx        <= idx_n;
      timer      <= timer_n;
      clr_ID_vld <= clr_n;
      result_vld <= rvld_n;
      granted    <= gr_n;
      denied     <= dn_n;
      locked     <= lk_n;
      fail_cnt   <= fc_n;
    end
  end
endmodule

// File: tb/tb_id_checker.sv
// tb_id_checker: directed and randomized checks of id_checker against a table-level reference model
module tb_id_checker;
  localparam int N = 8;
  localparam int MF = 3;
  localparam int LC = 1000;

  logic       clk = 0;
  logic       rst, ID_vld, clr_ID_vld, wr_en, wr_valid;
  logic [7:0] ID, wr_data;
  logic [2:0] wr_idx;
  logic       result_vld, granted, denied, result_ack, locked;
  logic [3:0] fail_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_data [N];
  logic       m_vld  [N];
  int         m_fails = 0;
  logic       m_locked = 0;
  logic [7:0] pool [4] = '{8'hA5, 8'h3C, 8'h5A, 8'h00};

  id_checker #(.NUM_ENTRIES(N), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .ID_vld(ID_vld), .ID(ID), .clr_ID_vld(clr_ID_vld),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_valid(wr_valid),
    .result_vld(result_vld), .granted(granted), .denied(denied),
    .result_ack(result_ack), .locked(locked), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_hit(input logic [7:0] id);
    for (int i = 0; i < N; i++) if (m_vld[i] && m_data[i] == id) return i;
    return -1;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_data[i] = 8'h00;
      m_vld[i]  = 1'b0;
    end
    m_fails  = 0;
    m_locked = 0;
  endtask

  task automatic wr(input int i, input logic [7:0] d, input logic v);
    wr_en = 1; wr_idx = 3'(i); wr_data = d; wr_valid = v;
    step();
    wr_en = 0;
    m_data[i] = d;
    m_vld[i]  = v;
  endtask

  task automatic do_search(input logic [7:0] id, input int hold, input logic pend, input logic [7:0] pend_id);
    int k, lat, c;
    logic g;
    chk("clr_pulse", clr_ID_vld, 1);
    ID_vld = 0;
    k = first_hit(id);
    g = (k >= 0);
    lat = g ? k + 1 : N;
    c = 0;
    do begin
      step();
      c++;
      if (c == 1) chk("clr_single", clr_ID_vld, 0);
    end while (!result_vld && c < 20);
    chk("latency", c, lat);
    chk("granted", granted, g);
    chk("denied", denied, !g);
    if (pend) begin
      ID_vld = 1;
      ID = pend_id;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_vld", result_vld, 1);
      chk("hold_granted", granted, g);
      if (pend) chk("bp_no_clr", clr_ID_vld, 0);
    end
    result_ack = 1;
    step();
    result_ack = 0;
    m_fails  = g ? 0 : m_fails + 1;
    m_locked = (m_fails == MF);
    chk("ack_vld", result_vld, 0);
    chk("fail_cnt", fail_cnt, m_fails);
    chk("locked", locked, m_locked);
    if (pend) chk("bp_no_clr_ack", clr_ID_vld, 0);
  endtask

  task automatic present(input logic [7:0] id, input int hold);
    ID_vld = 1;
    ID = id;
    step();
    do_search(id, hold, 0, 8'h00);
  endtask

  task automatic wait_unlock();
    int n;
    n = 0;
    while (locked && n < LC + 10) begin
      step();
      n++;
    end
    chk("unlock", locked, 0);
    chk("unlock_fail_cnt", fail_cnt, 0);
    m_fails  = 0;
    m_locked = 0;
  endtask

  initial begin
    int n;
    logic saw_result;
    logic [7:0] rid;
    rst = 1; ID_vld = 0; ID = 0; wr_en = 0; wr_idx = 0; wr_data = 0; wr_valid = 0; result_ack = 0;
    clear_model();
    step();
    step();
    rst = 0;
    chk("rst_clr", clr_ID_vld, 0);
    chk("rst_result_vld", result_vld, 0);
    chk("rst_granted", granted, 0);
    chk("rst_denied", denied, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail_cnt", fail_cnt, 0);

    wr(3, 8'hA5, 1);
    present(8'hA5, 5);

    wr(0, 8'h3C, 0);
    present(8'h3C, 0);

    ID_vld = 1;
    ID = 8'h22;
    step();
    do_search(8'h22, 3, 1, 8'h11);
    step();
    do_search(8'h11, 1, 0, 8'h00);

    ID_vld = 1;
    ID = 8'hA5;
    step();
    chk("lock_clr", clr_ID_vld, 1);
    chk("lock_no_result", result_vld, 0);
    ID_vld = 0;
    step();
    chk("lock_clr_single", clr_ID_vld, 0);
    n = 2;
    saw_result = 0;
    while (locked && n < LC + 100) begin
      step();
      n++;
      if (result_vld) saw_result = 1;
    end
    chk("lock_len", n, LC);
    chk("lock_saw_result", saw_result, 0);
    chk("lock_fail_cnt", fail_cnt, 0);
    m_fails = 0;
    m_locked = 0;

    wr(2, 8'h77, 1);
    ID_vld = 1;
    ID = 8'h77;
    step();
    chk("col_clr", clr_ID_vld, 1);
    ID_vld = 0;
    step();
    step();
    wr_en = 1; wr_idx = 3'd2; wr_data = 8'h00; wr_valid = 1;
    step();
    wr_en = 0;
    m_data[2] = 8'h00;
    chk("col_vld", result_vld, 1);
    chk("col_granted", granted, 1);
    result_ack = 1;
    step();
    result_ack = 0;
    m_fails = 0;
    chk("col_fail_cnt", fail_cnt, 0);
    present(8'h77, 0);

    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, N - 1), pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
      rid = ($urandom_range(0, 4) == 4) ? 8'($urandom) : pool[$urandom_range(0, 3)];
      present(rid, $urandom_range(0, 3));
      if (m_locked) wait_unlock();
    end

    wr(3, 8'hA5, 1);
    ID_vld = 1;
    ID = 8'hA5;
    step();
    ID_vld = 0;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    clear_model();
    chk("mrst_clr", clr_ID_vld, 0);
    chk("mrst_result_vld", result_vld, 0);
    chk("mrst_granted", granted, 0);
    chk("mrst_locked", locked, 0);
    chk("mrst_fail_cnt", fail_cnt, 0);
    present(8'hA5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
